sine_period_meter: RTL
======================

# sine_period_meter

Receive-side companion to the sine-table DDS. Consumes the DDS sample stream, detects rising zero crossings with hysteresis, and measures the period in samples. It averages over 2^AVG_LOG2 periods and reports the result so loopback benches and the tuning logic can recover the played note's frequency. Sits downstream of the DDS sine output, in the same clock domain.

## Interface
- W, 32: sample width; samples are signed two's complement.
- CW, 20: period counter/result width.
- HYST, 1024: hysteresis threshold magnitude, must satisfy 0 < HYST < 2^(W-1).
- AVG_LOG2, 2: log2 of the number of periods averaged per result (0 = no averaging).
- MAX_PERIOD, 2^CW-1: timeout sample count.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- SAMPLE  in  W  signed sample, qualified by SAMPLE_VALID.
- SAMPLE_VALID  in  1  one-cycle strobe per sample; may be held high every cycle.
- PERIOD  out  CW  averaged period in samples, truncated.
- PERIOD_VALID  out  1  one-cycle pulse when PERIOD updates.
- LOCKED  out  1  high once the first result is produced; cleared on timeout.

## Operation
- Only cycles with SAMPLE_VALID=1 advance any state. Idle cycles are ignored entirely.
- Hysteresis FSM:
  - S_FIND_NEG: wait for SAMPLE <= -HYST, then go to S_FIND_POS.
  - S_FIND_POS: wait for SAMPLE >= +HYST. That sample is a rising crossing; go to S_FIND_NEG.
  - Samples strictly between -HYST and +HYST never change state.
- Reset state is S_FIND_NEG, with the `have_ref` flag cleared.
- Sample counter `cnt` (CW bits):
  - Increments on every valid sample.
  - On a crossing, the measured period is cnt+1, counting samples after the previous crossing up to and including this one.
  - `cnt` is then reloaded to 0.
- First crossing after reset or timeout only sets `have_ref`. No period is taken from it.
- Accumulator `acc` (CW+AVG_LOG2 bits) sums periods. `n` counts periods from 0 to 2^AVG_LOG2-1.
  - When the 2^AVG_LOG2-th period is added: PERIOD <= (acc+period) >> AVG_LOG2, PERIOD_VALID pulses, LOCKED <= 1.
  - acc and n are then cleared.
- Timeout: if `cnt` reaches MAX_PERIOD on a valid sample, the block resets its measurement:
  - LOCKED <= 0; have_ref, acc, n and cnt are cleared; FSM returns to S_FIND_NEG.
  - PERIOD holds its last value.
- Timeout has priority over a crossing on the same sample.
- PERIOD never wraps. A period of MAX_PERIOD or more always times out.

## Timing
- All outputs are registered. Reset values: PERIOD=0, PERIOD_VALID=0, LOCKED=0.
- PERIOD_VALID is high exactly one cycle, the cycle after the valid sample that completes the averaging window. PERIOD is stable from that cycle until the next pulse.
- LOCKED rises in the same cycle as the first PERIOD_VALID.
- LOCKED falls the cycle after the timeout sample.
- Minimum measurable period is 2 samples. With SAMPLE_VALID continuously high, throughput is 1 sample per cycle with no stalls.
- Asserting RESET low mid-window discards the partial measurement immediately, asynchronously. Operation resumes from S_FIND_NEG on the first edge after release.

## Structure
- Package `sine_meter_pkg`:
  - State enum {S_FIND_NEG, S_FIND_POS}.
  - Default constants for W, CW, HYST, AVG_LOG2.
- One sub-module `sine_xdet`: the hysteresis comparator plus the FSM, outputting a one-cycle `xing` strobe. The parent holds the counter, accumulator, timeout and output registers.

## Test plan
- Square wave, W=32, HYST=1024, AVG_LOG2=0: repeat 10×(+2000) then 10×(-2000).
  - First PERIOD_VALID follows the second rising crossing, with PERIOD=20.
  - LOCKED=1 from that cycle; every 20 samples another pulse with PERIOD=20.
- Full DDS loopback, AVG_LOG2=2: connect the sine DDS at NOTE=69, CLK=10 MHz, one sample per clock.
  - PERIOD = floor(10e6/440) ±1 = 22727 ±1.
  - PERIOD_VALID occurs once per 4 periods.
- Hysteresis: sine of amplitude 1500 with ±900 pseudo-random noise superimposed near zero, true period 64.
  - Every reported PERIOD = 64.
  - No spurious PERIOD_VALID.
- Timeout: lock on period 20, then hold SAMPLE=0 with CW=8, MAX_PERIOD=255.
  - LOCKED falls on the 255th zero sample.
  - No PERIOD_VALID is produced.
  - After the square wave restarts, relock requires two crossings again.
- Gapped valid: same square wave as the first scenario, with SAMPLE_VALID high only every 3rd cycle.
  - PERIOD=20, and PERIOD_VALID is spaced 60 cycles apart.
- Reset mid-window: RESET low for 1 cycle after 3 of 4 periods are accumulated.
  - Outputs go to 0 immediately.
  - The next PERIOD_VALID occurs only after 1+4 further crossings.

Source files
------------

// File: rtl/sine_meter_pkg.sv
// rtl/sine_meter_pkg.sv - shared types and default constants for the sine period meter
//
// Purpose: zero-crossing detector state encoding and default parameter values
//          used by sine_xdet and sine_period_meter.
// Ports:   none (package).
package sine_meter_pkg;

    // Hysteresis detector states: arm on a clearly negative sample, then
    // report the first clearly positive sample as the rising crossing.
    typedef enum logic {
        S_FIND_NEG = 1'b0,
        S_FIND_POS = 1'b1
    } xdet_state_e;

    localparam int DEF_W        = 32;
    localparam int DEF_CW       = 20;
    localparam int DEF_HYST     = 1024;
    localparam int DEF_AVG_LOG2 = 2;

endpackage

// File: rtl/sine_xdet.sv
// rtl/sine_xdet.sv - hysteresis rising zero-crossing detector
//
// Purpose: compares each valid sample against +/-HYST and runs the
//          FIND_NEG / FIND_POS state machine; flags the sample that
//          completes a rising crossing.
// Ports:
//   clk_i     in   1  clock, rising edge
//   rst_ni    in   1  asynchronous active-low reset
//   sample_i  in   W  signed sample
//   valid_i   in   1  sample qualifier; idle cycles leave the state untouched
//   clear_i   in   1  force the detector back to S_FIND_NEG on this valid sample
//   xing_o    out  1  high during the valid sample that is a rising crossing
module sine_xdet
    import sine_meter_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int HYST = DEF_HYST
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] sample_i,
    input  logic         valid_i,
    input  logic         clear_i,
    output logic         xing_o
);

    localparam logic signed [W-1:0] POS_TH = W'(HYST);
    localparam logic signed [W-1:0] NEG_TH = -POS_TH;

    xdet_state_e state_q;
    xdet_state_e state_d;
    logic        at_pos;
    logic        at_neg;

    always_comb begin
        at_pos = $signed(sample_i) >= POS_TH;
        at_neg = $signed(sample_i) <= NEG_TH;
    end

    // The strobe is decoded from the registered state and the current sample
    // so the parent can close the period on the crossing sample itself and
    // still present registered results one cycle later.
    always_comb begin
        xing_o = valid_i && (state_q == S_FIND_POS) && at_pos;
    end

    always_comb begin
        state_d = state_q;
        if (valid_i) begin
            if (clear_i) begin
                state_d = S_FIND_NEG;
            end else begin
                case (state_q)
                    S_FIND_NEG: if (at_neg) state_d = S_FIND_POS;
                    S_FIND_POS: if (at_pos) state_d = S_FIND_NEG;
                    default:    state_d = S_FIND_NEG;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_FIND_NEG;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/sine_period_meter.sv
// rtl/sine_period_meter.sv - averaged sine period meter (top)
//
// Purpose: counts samples between rising zero crossings, averages
//          2^AVG_LOG2 periods and reports the truncated mean.
// Ports:
//   CLK           in   1   clock, rising edge
//   RESET         in   1   asynchronous active-low reset
//   SAMPLE        in   W   signed sample
//   SAMPLE_VALID  in   1   sample qualifier
//   PERIOD        out  CW  averaged period in samples
//   PERIOD_VALID  out  1   one-cycle pulse when PERIOD updates
//   LOCKED        out  1   set with the first result, cleared by timeout
module sine_period_meter
    import sine_meter_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int CW         = DEF_CW,
    parameter int HYST       = DEF_HYST,
    parameter int AVG_LOG2   = DEF_AVG_LOG2,
    parameter int MAX_PERIOD = (1 << CW) - 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [W-1:0]  SAMPLE,
    input  logic          SAMPLE_VALID,
    output logic [CW-1:0] PERIOD,
    output logic          PERIOD_VALID,
    output logic          LOCKED
);

    localparam int AW = CW + AVG_LOG2;
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    // cnt_q holds MAX_PERIOD-1 on the sample whose period would reach MAX_PERIOD.
    localparam logic [CW-1:0] CNT_TIMEOUT = CW'(MAX_PERIOD - 1);
    localparam logic [NW-1:0] N_LAST      = NW'((1 << AVG_LOG2) - 1);

    logic [CW-1:0] cnt_q,      cnt_d;
    logic          have_ref_q, have_ref_d;
    logic [AW-1:0] acc_q,      acc_d;
    logic [NW-1:0] n_q,        n_d;
    logic [CW-1:0] period_q,   period_d;
    logic          pv_q,       pv_d;
    logic          locked_q,   locked_d;

    logic          xing;
    logic          timeout;
    logic [CW-1:0] meas;
    logic [AW-1:0] sum;

    sine_xdet #(
        .W    (W),
        .HYST (HYST)
    ) u_xdet (
        .clk_i    (CLK),
        .rst_ni   (RESET),
        .sample_i (SAMPLE),
        .valid_i  (SAMPLE_VALID),
        .clear_i  (timeout),
        .xing_o   (xing)
    );

    always_comb begin
        timeout = SAMPLE_VALID && (cnt_q == CNT_TIMEOUT);
        // Samples after the previous crossing up to and including this one.
        // Cannot wrap: any count that would reach MAX_PERIOD times out first.
        meas    = cnt_q + CW'(1);
        // Holds at most 2^AVG_LOG2 periods below 2^CW, so AW bits suffice.
        sum     = acc_q + AW'(meas);
    end

    always_comb begin
        cnt_d      = cnt_q;
        have_ref_d = have_ref_q;
        acc_d      = acc_q;
        n_d        = n_q;
        period_d   = period_q;
        pv_d       = 1'b0;
        locked_d   = locked_q;

        if (SAMPLE_VALID) begin
            if (timeout) begin
                // Drop the measurement but keep the last reported PERIOD.
                cnt_d      = '0;
                have_ref_d = 1'b0;
                acc_d      = '0;
                n_d        = '0;
                locked_d   = 1'b0;
            end else if (xing) begin
                cnt_d = '0;
                if (!have_ref_q) begin
                    // First crossing only anchors the count.
                    have_ref_d = 1'b1;
                end else if (n_q == N_LAST) begin
                    period_d = CW'(sum >> AVG_LOG2);
                    pv_d     = 1'b1;
                    locked_d = 1'b1;
                    acc_d    = '0;
                    n_d      = '0;
                end else begin
                    acc_d = sum;
                    n_d   = n_q + NW'(1);
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt_q      <= '0;
            have_ref_q <= 1'b0;
            acc_q      <= '0;
            n_q        <= '0;
            period_q   <= '0;
            pv_q       <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            have_ref_q <= have_ref_d;
            acc_q      <= acc_d;
            n_q        <= n_d;
            period_q   <= period_d;
            pv_q       <= pv_d;
            locked_q   <= locked_d;
        end
    end

    assign PERIOD       = period_q;
    assign PERIOD_VALID = pv_q;
    assign LOCKED       = locked_q;

endmodule
